bram_bank_reader: RTL and testbench

- Parametrised multi-bank BRAM read engine. Successor to the fixed two-bank combinational read mux.
- Splits a flat byte address across BANKS interleaved BRAMs using a configurable bank-select bit field.
- Issues reads with a valid/ready request handshake and tracks BRAM read latency with a tag pipeline.
- Buffers returned data in an output FIFO so the consumer may stall. Sits between memory-side consumers (video/DMA fetch) and the BRAM IP master ports.

---
 rtl/bram_pkg.sv | 31 +++
 rtl/bram_rsp_fifo.sv | 49 ++++
 rtl/bram_bank_reader.sv | 136 +++++++++++++
 tb/tb_bram_bank_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared helpers for the banked BRAM reader: width defaults, clog2 and the
// bank-select field arithmetic applied to a flat byte address.
package bram_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 21;
  localparam int DEFAULT_DATA_WIDTH = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Both helpers work on a 64-bit zero-extended address so one definition
  // serves every parameterisation; callers keep only the bits they need.
  function automatic logic [63:0] bank_field(input logic [63:0] addr,
                                             input int bank_bit, input int sb);
    return (addr >> bank_bit) & ((64'd1 << sb) - 64'd1);
  endfunction

  function automatic logic [63:0] strip_bank(input logic [63:0] addr,
                                             input int bank_bit, input int sb);
    logic [63:0] low_mask;
    low_mask = (64'd1 << bank_bit) - 64'd1;
    return ((addr >> (bank_bit + sb)) << bank_bit) | (addr & low_mask);
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Registered first-word-fall-through FIFO holding returned read data; the
// occupancy count is exported so the reader can derive request credits.
module bram_rsp_fifo import bram_pkg::*; #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [clog2(DEPTH):0]  count
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_bank_reader.sv
// Multi-bank BRAM read engine: decodes the bank field, tracks read latency
// with a never-stalling tag pipeline and buffers data in an output FIFO.
module bram_bank_reader import bram_pkg::*; #(
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int BANKS           = 2,
  parameter int BANK_BIT        = 3,
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int READ_LATENCY    = 1,
  parameter int FIFO_DEPTH      = 4,
  localparam int SB             = clog2(BANKS)
) (
  input  logic                              clk_memory,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [SB-1:0]                     rsp_bank,
  output logic                              busy,
  output logic [BANKS-1:0]                  bram_clk,
  output logic [BANKS-1:0]                  bram_en,
  output logic [BANKS-1:0]                  bram_we,
  output logic [BANKS*BRAM_ADDR_WIDTH-1:0]  bram_addr,
  output logic [BANKS*DATA_WIDTH-1:0]       bram_din,
  input  logic [BANKS*DATA_WIDTH-1:0]       bram_dout
);

  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam int EW = SB + DATA_WIDTH;

  if (BANK_BIT + SB > ADDR_WIDTH) begin : g_bad_bank_bit
    $error("bank field exceeds ADDR_WIDTH");
  end
  if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least READ_LATENCY+1");
  end
  if ((BANKS < 2) || ((BANKS & (BANKS - 1)) != 0)) begin : g_bad_banks
    $error("BANKS must be a power of two >= 2");
  end

  // Handshakes: a request transfers on a rising edge with req_valid &
  // req_ready, a response with rsp_valid & rsp_ready; valid never waits on ready.
  logic [63:0]                addr_ext;
  logic [63:0]                bank_ext;
  logic [63:0]                strip_ext;
  logic [SB-1:0]              req_bank;
  logic [BRAM_ADDR_WIDTH-1:0] bank_addr;
  logic                       unused_bits;
  logic                       accept;
  logic                       run;

  assign addr_ext    = 64'(req_addr);
  assign bank_ext    = bank_field(addr_ext, BANK_BIT, SB);
  assign strip_ext   = strip_bank(addr_ext, BANK_BIT, SB);
  assign req_bank    = bank_ext[SB-1:0];
  assign bank_addr   = strip_ext[BRAM_ADDR_WIDTH-1:0];
  assign unused_bits = ^{bank_ext[63:SB], strip_ext[63:BRAM_ADDR_WIDTH]};

  assign accept    = req_valid && req_ready;
  assign bram_clk  = {BANKS{clk_memory}};
  assign bram_we   = '0;
  assign bram_din  = '0;
  assign bram_addr = {BANKS{bank_addr}};

  always_comb begin
    bram_en = '0;
    for (int b = 0; b < BANKS; b++) begin
      bram_en[b] = accept && (req_bank == SB'(b));
    end
  end

  // Holds req_ready low until the first edge after reset is released.
  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) run <= 1'b0;
    else       run <= 1'b1;
  end

  logic [READ_LATENCY-1:0] tag_v;
  logic [SB-1:0]           tag_b [READ_LATENCY];

  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_b[i] <= '0;
    end else begin
      tag_v[0] <= accept;
      tag_b[0] <= req_bank;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_b[i] <= tag_b[i-1];
      end
    end
  end

  logic                  push;
  logic [SB-1:0]         push_bank;
  logic [DATA_WIDTH-1:0] push_data;
  logic [EW-1:0]         head;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           used;

  assign push      = tag_v[READ_LATENCY-1];
  assign push_bank = tag_b[READ_LATENCY-1];
  assign push_data = bram_dout[push_bank*DATA_WIDTH +: DATA_WIDTH];

  bram_rsp_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_memory),
    .reset     (reset),
    .push      (push),
    .push_data ({push_bank, push_data}),
    .pop       (rsp_ready),
    .pop_data  (head),
    .count     (fifo_count)
  );

  // Credits use only registered state, so rsp_ready never reaches req_ready.
  always_comb begin
    used = {1'b0, fifo_count};
    for (int i = 0; i < READ_LATENCY; i++) begin
      used = used + {{CW{1'b0}}, tag_v[i]};
    end
  end

  assign req_ready = run && (used < (CW+1)'(FIFO_DEPTH));
  assign rsp_valid = (fifo_count != '0);
  assign rsp_data  = rsp_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rsp_bank  = rsp_valid ? head[EW-1:DATA_WIDTH] : '0;
  assign busy      = (|tag_v) || rsp_valid;

endmodule

// File: tb/tb_bram_bank_reader.sv
// Directed bench for bram_bank_reader: a default two-bank instance and a
// four-bank, two-cycle-latency instance, each fed by a behavioural BRAM.
module tb_bram_bank_reader;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [20:0] req_addr;
  logic [7:0]  rsp_data;
  logic [0:0]  rsp_bank;
  logic [1:0]  bram_clk, bram_en, bram_we;
  logic [31:0] bram_addr;
  logic [15:0] bram_din, bram_dout;

  logic        req_valid4, req_ready4, rsp_valid4, rsp_ready4, busy4;
  logic [20:0] req_addr4;
  logic [7:0]  rsp_data4;
  logic [1:0]  rsp_bank4;
  logic [3:0]  bram_clk4, bram_en4, bram_we4;
  logic [63:0] bram_addr4;
  logic [31:0] bram_din4, bram_dout4;
  logic [7:0]  stage4 [4];

  int pass_cnt = 0;
  int total_cnt = 0;
  int acc_cnt = 0;
  int cyc = 0;
  logic [8:0] obs_q[$];
  int         obs_t[$];
  logic [8:0] exp_q[$];
  logic [9:0] obs4_q[$];
  logic [9:0] exp4_q[$];

  bram_bank_reader dut (
    .clk_memory (clk), .reset (reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
    .rsp_bank (rsp_bank), .busy (busy),
    .bram_clk (bram_clk), .bram_en (bram_en), .bram_we (bram_we),
    .bram_addr (bram_addr), .bram_din (bram_din), .bram_dout (bram_dout)
  );

  bram_bank_reader #(.BANKS(4), .BANK_BIT(0), .READ_LATENCY(2)) dut4 (
    .clk_memory (clk), .reset (reset),
    .req_valid (req_valid4), .req_ready (req_ready4), .req_addr (req_addr4),
    .rsp_valid (rsp_valid4), .rsp_ready (rsp_ready4), .rsp_data (rsp_data4),
    .rsp_bank (rsp_bank4), .busy (busy4),
    .bram_clk (bram_clk4), .bram_en (bram_en4), .bram_we (bram_we4),
    .bram_addr (bram_addr4), .bram_din (bram_din4), .bram_dout (bram_dout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word(bank, addr) = addr*3 + bank*0x44 + 0x5E (mod 256).
  function automatic logic [7:0] mem_word(input int b, input logic [15:0] a);
    return 8'(int'(a) * 3 + b * 68 + 94);
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (bram_en[b]) bram_dout[b*8 +: 8] <= mem_word(b, bram_addr[b*16 +: 16]);
    end
    for (int b = 0; b < 4; b++) begin
      if (bram_en4[b]) stage4[b] <= mem_word(b, bram_addr4[b*16 +: 16]);
      bram_dout4[b*8 +: 8] <= stage4[b];
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rsp_valid && rsp_ready) begin
      obs_q.push_back({rsp_bank, rsp_data});
      obs_t.push_back(cyc);
    end
    if (req_valid && req_ready) acc_cnt++;
    if (rsp_valid4 && rsp_ready4) obs4_q.push_back({rsp_bank4, rsp_data4});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 0; req_addr = '0; rsp_ready = 0;
    req_valid4 = 0; req_addr4 = '0; rsp_ready4 = 0;
    repeat (2) tick();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", req_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (bram_en !== 2'b00) $display("FAIL rst_bram_en got %b want 00", bram_en); else pass_cnt++;
    total_cnt++; if (rsp_data !== 8'h00) $display("FAIL rst_rsp_data got %h want 00", rsp_data); else pass_cnt++;
    total_cnt++; if (rsp_bank !== 1'b0) $display("FAIL rst_rsp_bank got %h want 0", rsp_bank); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL rel_req_ready_early got %b want 0", req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL rel_req_ready got %b want 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    rsp_ready = 0; acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_addr = 21'(i * 8);
      tick();
    end
    req_valid = 0;
    total_cnt++; if (acc_cnt !== 3) $display("FAIL mid_accepts got %0d want 3", acc_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_pre got %b want 1", busy); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else pass_cnt++;
    tick();
    reset = 1'b0; rsp_ready = 1;
    obs_q.delete();
    tick();
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL mid_req_ready got %b want 1", req_ready); else pass_cnt++;
    repeat (4) tick();
    total_cnt++; if (obs_q.size() !== 0) $display("FAIL mid_stale got %0d want 0", obs_q.size()); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_after got %b want 0", rsp_valid); else pass_cnt++;
    rsp_ready = 0;
  endtask

  task automatic test_single_read();
    obs_q.delete();
    rsp_ready = 0;
    req_addr = 21'h00009; req_valid = 1;
    #1;
    total_cnt++; if (bram_en !== 2'b10) $display("FAIL single_en got %b want 10", bram_en); else pass_cnt++;
    total_cnt++; if (bram_addr[31:16] !== 16'h0001) $display("FAIL single_addr got %h want 0001", bram_addr[31:16]); else pass_cnt++;
    total_cnt++; if (bram_addr[15:0] !== 16'h0001) $display("FAIL single_addr0 got %h want 0001", bram_addr[15:0]); else pass_cnt++;
    total_cnt++; if (bram_we !== 2'b00 || bram_din !== 16'h0) $display("FAIL single_we_din got %b/%h want 00/0000", bram_we, bram_din); else pass_cnt++;
    tick();
    req_valid = 0;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_early got %b want 0", rsp_valid); else pass_cnt++;
    tick();
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL single_valid got %b want 1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_data !== 8'hA5) $display("FAIL single_data got %h want a5", rsp_data); else pass_cnt++;
    total_cnt++; if (rsp_bank !== 1'b1) $display("FAIL single_bank got %h want 1", rsp_bank); else pass_cnt++;
    rsp_ready = 1;
    tick();
    total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_drain got %b/%b want 0/0", rsp_valid, busy); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== 1) $display("FAIL single_count got %0d want 1", obs_q.size()); else pass_cnt++;
    rsp_ready = 0;
  endtask

  task automatic test_interleaved();
    int          a_tab[4]  = '{0, 8, 16, 24};
    logic [1:0]  en_tab[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] ba_tab[4] = '{16'd0, 16'd0, 16'd8, 16'd8};
    exp_q = '{9'h05E, 9'h1A2, 9'h076, 9'h1BA};
    obs_q.delete(); obs_t.delete();
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_addr = 21'(a_tab[i]);
      #1;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL il_ready[%0d] got %b want 1", i, req_ready); else pass_cnt++;
      total_cnt++; if (bram_en !== en_tab[i]) $display("FAIL il_en[%0d] got %b want %b", i, bram_en, en_tab[i]); else pass_cnt++;
      total_cnt++; if (bram_addr[(i%2)*16 +: 16] !== ba_tab[i]) $display("FAIL il_addr[%0d] got %h want %h", i, bram_addr[(i%2)*16 +: 16], ba_tab[i]); else pass_cnt++;
      tick();
    end
    req_valid = 0;
    for (int c = 0; c < 20 && busy; c++) tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL il_drain got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== 4) $display("FAIL il_count got %0d want 4", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL il_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (obs_t[3] - obs_t[0] !== 3) $display("FAIL il_rate got %0d want 3", obs_t[3] - obs_t[0]); else pass_cnt++;
    rsp_ready = 0;
  endtask

  task automatic test_backpressure();
    exp_q = '{9'h05E, 9'h1A2, 9'h076, 9'h1BA, 9'h08E, 9'h1D2, 9'h0A6, 9'h1EA};
    obs_q.delete();
    rsp_ready = 0; acc_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1; req_addr = 21'(acc_cnt * 8);
      tick();
    end
    total_cnt++; if (acc_cnt !== 4) $display("FAIL bp_accepts got %0d want 4", acc_cnt); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_ready got %b want 0", req_ready); else pass_cnt++;
    rsp_ready = 1;
    for (int c = 0; c < 40 && !(acc_cnt == 8 && !busy); c++) begin
      req_valid = (acc_cnt < 8); req_addr = 21'(acc_cnt * 8);
      tick();
    end
    req_valid = 0;
    total_cnt++; if (acc_cnt !== 8 || busy !== 1'b0) $display("FAIL bp_done got %0d/%b want 8/0", acc_cnt, busy); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== 8) $display("FAIL bp_count got %0d want 8", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL bp_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
    rsp_ready = 0;
  endtask

  task automatic test_full_push_pop();
    exp_q = '{9'h05E, 9'h1A2, 9'h076, 9'h1BA, 9'h08E};
    obs_q.delete();
    rsp_ready = 0; acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_addr = 21'(i * 8);
      tick();
    end
    total_cnt++; if (acc_cnt !== 4 || req_ready !== 1'b0) $display("FAIL fpp_fill got %0d/%b want 4/0", acc_cnt, req_ready); else pass_cnt++;
    req_addr = 21'(32); rsp_ready = 1;
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL fpp_no_comb got %b want 0", req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (req_ready !== 1'b1 || rsp_valid !== 1'b1) $display("FAIL fpp_level got %b/%b want 1/1", req_ready, rsp_valid); else pass_cnt++;
    tick();
    req_valid = 0;
    for (int c = 0; c < 20 && busy; c++) tick();
    total_cnt++; if (acc_cnt !== 5 || busy !== 1'b0) $display("FAIL fpp_done got %0d/%b want 5/0", acc_cnt, busy); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== 5) $display("FAIL fpp_count got %0d want 5", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL fpp_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
    rsp_ready = 0;
  endtask

  task automatic test_rl2_banks4();
    exp4_q = '{10'h05E, 10'h1A2, 10'h2E6, 10'h32A, 10'h061, 10'h1A5, 10'h2E9, 10'h32D};
    obs4_q.delete();
    rsp_ready4 = 1;
    for (int n = 0; n < 8; n++) begin
      req_valid4 = 1; req_addr4 = 21'(n);
      #1;
      total_cnt++; if (req_ready4 !== 1'b1) $display("FAIL rl2_ready[%0d] got %b want 1", n, req_ready4); else pass_cnt++;
      total_cnt++; if (bram_en4 !== 4'(1 << (n % 4))) $display("FAIL rl2_en[%0d] got %b want %b", n, bram_en4, 4'(1 << (n % 4))); else pass_cnt++;
      total_cnt++; if (bram_addr4[(n%4)*16 +: 16] !== 16'(n / 4)) $display("FAIL rl2_addr[%0d] got %h want %h", n, bram_addr4[(n%4)*16 +: 16], 16'(n / 4)); else pass_cnt++;
      if (n == 1 || n == 2) begin
        total_cnt++; if (rsp_valid4 !== 1'b0) $display("FAIL rl2_early[%0d] got %b want 0", n, rsp_valid4); else pass_cnt++;
      end
      if (n == 3) begin
        total_cnt++; if (rsp_valid4 !== 1'b1) $display("FAIL rl2_first got %b want 1", rsp_valid4); else pass_cnt++;
      end
      tick();
    end
    req_valid4 = 0;
    for (int c = 0; c < 20 && busy4; c++) tick();
    total_cnt++; if (busy4 !== 1'b0) $display("FAIL rl2_drain got %b want 0", busy4); else pass_cnt++;
    total_cnt++; if (obs4_q.size() !== 8) $display("FAIL rl2_count got %0d want 8", obs4_q.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (obs4_q[i] !== exp4_q[i]) $display("FAIL rl2_rsp[%0d] got %h want %h", i, obs4_q[i], exp4_q[i]); else pass_cnt++;
    end
    rsp_ready4 = 0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_single_read();
    test_interleaved();
    test_backpressure();
    test_full_push_pop();
    test_rl2_banks4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
